stereo_capture_arbiter: RTL and testbench

- Sequences capture of a left and a right camera frame into one shared frame buffer through a single write port.
- Each channel has start/clear controls and a valid/ready pixel stream.
- A round-robin arbiter shares the write port; address generation places the left frame at base 0 and the right frame at base FRAME_PIX.
- Sits between the per-camera pixel front ends and the frame buffer inside top; l_start/r_start/l_clear/r_clear are driven from top's ports.

---
 rtl/stereo_capture_arbiter.sv | 162 ++++++++++++++++
 tb/tb_stereo_capture_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/stereo_capture_arbiter.sv
// Captures a left and a right camera frame into one shared frame buffer write port.
// Each channel runs IDLE/ACTIVE/DONE; a round-robin arbiter grants one pixel per cycle.
module stereo_capture_arbiter #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned COLS   = 64,
    parameter int unsigned ROWS   = 48,
    parameter int unsigned ADDR_W = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              l_start,
    input  logic              r_start,
    input  logic              l_clear,
    input  logic              r_clear,
    input  logic              l_valid,
    input  logic [DATA_W-1:0] l_data,
    output logic              l_ready,
    input  logic              r_valid,
    input  logic [DATA_W-1:0] r_data,
    output logic              r_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              l_busy,
    output logic              r_busy,
    output logic              l_done,
    output logic              r_done
);

    localparam int unsigned       FRAME_PIX = COLS * ROWS;
    localparam int unsigned       CNT_W     = $clog2(FRAME_PIX);
    localparam logic [CNT_W-1:0]  LAST_PIX  = CNT_W'(FRAME_PIX - 1);
    localparam logic [ADDR_W-1:0] R_BASE    = ADDR_W'(FRAME_PIX);
    localparam logic              GRANT_L   = 1'b0;
    localparam logic              GRANT_R   = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } ch_state_t;

    ch_state_t        l_state, l_state_nxt, r_state, r_state_nxt;
    logic [CNT_W-1:0] l_cnt, l_cnt_nxt, r_cnt, r_cnt_nxt;
    logic             last_grant, last_grant_nxt;
    logic             elig_l, elig_r, grant_l, grant_r;

    // Clear removes a channel from arbitration in the same cycle it is asserted.
    always_comb begin
        elig_l  = l_valid && (l_state == ACTIVE) && !l_clear;
        elig_r  = r_valid && (r_state == ACTIVE) && !r_clear;
        grant_l = elig_l && (!elig_r || (last_grant == GRANT_R));
        grant_r = elig_r && (!elig_l || (last_grant == GRANT_L));
    end

    assign l_ready = grant_l;
    assign r_ready = grant_r;
    assign l_busy  = (l_state == ACTIVE);
    assign r_busy  = (r_state == ACTIVE);
    assign l_done  = (l_state == DONE);
    assign r_done  = (r_state == DONE);

    always_comb begin
        l_state_nxt    = l_state;
        l_cnt_nxt      = l_cnt;
        r_state_nxt    = r_state;
        r_cnt_nxt      = r_cnt;
        last_grant_nxt = last_grant;

        if (grant_l) begin
            last_grant_nxt = GRANT_L;
        end else if (grant_r) begin
            last_grant_nxt = GRANT_R;
        end

        if (l_clear) begin
            l_state_nxt = IDLE;
            l_cnt_nxt   = '0;
        end else begin
            case (l_state)
                IDLE: begin
                    if (l_start) begin
                        l_state_nxt = ACTIVE;
                        l_cnt_nxt   = '0;
                    end
                end
                ACTIVE: begin
                    if (grant_l) begin
                        if (l_cnt == LAST_PIX) begin
                            l_state_nxt = DONE;
                        end else begin
                            l_cnt_nxt = l_cnt + CNT_W'(1);
                        end
                    end
                end
                DONE:    l_state_nxt = DONE;
                default: l_state_nxt = IDLE;
            endcase
        end

        if (r_clear) begin
            r_state_nxt = IDLE;
            r_cnt_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (r_start) begin
                        r_state_nxt = ACTIVE;
                        r_cnt_nxt   = '0;
                    end
                end
                ACTIVE: begin
                    if (grant_r) begin
                        if (r_cnt == LAST_PIX) begin
                            r_state_nxt = DONE;
                        end else begin
                            r_cnt_nxt = r_cnt + CNT_W'(1);
                        end
                    end
                end
                DONE:    r_state_nxt = DONE;
                default: r_state_nxt = IDLE;
            endcase
        end
    end

    // Reset leaves last_grant on the right so the left wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l_state    <= IDLE;
            r_state    <= IDLE;
            l_cnt      <= '0;
            r_cnt      <= '0;
            last_grant <= GRANT_R;
        end else begin
            l_state    <= l_state_nxt;
            r_state    <= r_state_nxt;
            l_cnt      <= l_cnt_nxt;
            r_cnt      <= r_cnt_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    // Write port: address and data hold their last values when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= grant_l || grant_r;
            if (grant_l) begin
                mem_addr  <= ADDR_W'(l_cnt);
                mem_wdata <= l_data;
            end else if (grant_r) begin
                mem_addr  <= R_BASE + ADDR_W'(r_cnt);
                mem_wdata <= r_data;
            end
        end
    end

endmodule

// File: tb/tb_stereo_capture_arbiter.sv
// Directed bench for stereo_capture_arbiter: a small behavioural model predicts ready,
// status and writes; expected writes flow through a scoreboard queue.
module tb_stereo_capture_arbiter;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned COLS   = 64;
    localparam int unsigned ROWS   = 48;
    localparam int unsigned ADDR_W = 13;
    localparam int          FP     = COLS * ROWS;
    localparam int          M_IDLE = 0;
    localparam int          M_ACT  = 1;
    localparam int          M_DONE = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              l_start = 1'b0, r_start = 1'b0, l_clear = 1'b0, r_clear = 1'b0;
    logic              l_valid = 1'b0, r_valid = 1'b0;
    logic [DATA_W-1:0] l_data = '0, r_data = '0;
    logic              l_ready, r_ready, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              l_busy, r_busy, l_done, r_done;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t sb[$];
    int  vectors = 0;
    int  miscompares = 0;
    int  writes = 0;
    int  w0;
    int  m_ls, m_rs, m_lc, m_rc;
    bit  m_last;

    stereo_capture_arbiter #(
        .DATA_W(DATA_W), .COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .l_start(l_start), .r_start(r_start), .l_clear(l_clear), .r_clear(r_clear),
        .l_valid(l_valid), .l_data(l_data), .l_ready(l_ready),
        .r_valid(r_valid), .r_data(r_data), .r_ready(r_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .l_busy(l_busy), .r_busy(r_busy), .l_done(l_done), .r_done(r_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic upd(inout int st, inout int cnt, input bit s, input bit c, input bit g);
        if (c) begin
            st = M_IDLE; cnt = 0;
        end else if (st == M_IDLE && s) begin
            st = M_ACT; cnt = 0;
        end else if (st == M_ACT && g) begin
            if (cnt == FP - 1) st = M_DONE;
            else cnt++;
        end
    endtask

    task automatic step(input bit ls, input bit rs, input bit lc, input bit rc,
                        input bit lv, input bit rv, input logic [7:0] ld, input logic [7:0] rd);
        bit  el, er, gl, gr;
        wr_t w;
        @(negedge clk);
        l_start = ls; r_start = rs; l_clear = lc; r_clear = rc;
        l_valid = lv; r_valid = rv; l_data = ld; r_data = rd;
        #1;
        el = lv && (m_ls == M_ACT) && !lc;
        er = rv && (m_rs == M_ACT) && !rc;
        gl = el && (!er || m_last);
        gr = er && (!el || !m_last);
        chk("l_ready", 32'(l_ready), 32'(gl));
        chk("r_ready", 32'(r_ready), 32'(gr));
        if (gl) begin
            w.addr = ADDR_W'(m_lc); w.data = ld; sb.push_back(w);
        end
        if (gr) begin
            w.addr = ADDR_W'(FP + m_rc); w.data = rd; sb.push_back(w);
        end
        upd(m_ls, m_lc, ls, lc, gl);
        upd(m_rs, m_rc, rs, rc, gr);
        if (gl) m_last = 1'b0;
        if (gr) m_last = 1'b1;
        @(posedge clk);
        #1;
        chk("mem_we", 32'(mem_we), 32'(gl || gr));
        if (mem_we === 1'b1) writes++;
        if ((gl || gr) && sb.size() > 0) begin
            w = sb.pop_front();
            chk("mem_addr", 32'(mem_addr), 32'(w.addr));
            chk("mem_wdata", 32'(mem_wdata), 32'(w.data));
        end
        chk("l_busy", 32'(l_busy), 32'(m_ls == M_ACT));
        chk("l_done", 32'(l_done), 32'(m_ls == M_DONE));
        chk("r_busy", 32'(r_busy), 32'(m_rs == M_ACT));
        chk("r_done", 32'(r_done), 32'(m_rs == M_DONE));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        l_start = 0; r_start = 0; l_clear = 0; r_clear = 0; l_valid = 0; r_valid = 0;
        #1;
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_wdata", 32'(mem_wdata), 0);
        chk("rst_status", {28'd0, l_busy, r_busy, l_done, r_done}, 0);
        chk("rst_ready", {30'd0, l_ready, r_ready}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        m_ls = M_IDLE; m_rs = M_IDLE; m_lc = 0; m_rc = 0; m_last = 1'b1;
        sb.delete();
    endtask

    initial begin
        #2;
        do_reset();

        // Left frame alone, data = counter[7:0].
        step(1, 0, 0, 0, 0, 0, 8'd0, 8'd0);
        w0 = writes;
        for (int i = 0; i < FP; i++) step(0, 0, 0, 0, 1, 0, 8'(m_lc), 8'd0);
        chk("t1_writes", 32'(writes - w0), 32'(FP));
        chk("t1_last_addr", 32'(mem_addr), 32'(FP - 1));
        chk("t1_l_done", 32'(l_done), 1);
        chk("t1_l_busy", 32'(l_busy), 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0, 8'hEE, 8'd0);

        // Both channels continuously valid: strict alternation from left.
        do_reset();
        step(1, 1, 0, 0, 0, 0, 8'd0, 8'd0);
        w0 = writes;
        for (int i = 0; i < 2 * FP; i++)
            step(0, 0, 0, 0, 1, 1, 8'(m_lc), 8'(m_rc ^ 8'h5A));
        chk("t2_writes", 32'(writes - w0), 32'(2 * FP));
        chk("t2_done", {30'd0, l_done, r_done}, 3);

        // Right valid every other cycle, left continuous.
        do_reset();
        step(1, 1, 0, 0, 0, 0, 8'd0, 8'd0);
        w0 = writes;
        for (int i = 0; i < 8000 && !(m_ls == M_DONE && m_rs == M_DONE); i++)
            step(0, 0, 0, 0, 1, (i % 2) == 0, 8'(m_lc + 3), 8'(m_rc + 7));
        chk("t3_writes", 32'(writes - w0), 32'(2 * FP));
        chk("t3_done", {30'd0, l_done, r_done}, 3);

        // Clear after 100 pixels, then restart from address 0.
        do_reset();
        step(1, 0, 0, 0, 0, 0, 8'd0, 8'd0);
        for (int i = 0; i < 100; i++) step(0, 0, 0, 0, 1, 0, 8'(m_lc), 8'd0);
        w0 = writes;
        step(0, 0, 1, 0, 1, 0, 8'hAA, 8'd0);
        chk("t4_clear_nowrite", 32'(writes - w0), 0);
        chk("t4_clear_busy", 32'(l_busy), 0);
        step(1, 0, 0, 0, 0, 0, 8'd0, 8'd0);
        step(0, 0, 0, 0, 1, 0, 8'h3C, 8'd0);
        chk("t4_restart_addr", 32'(mem_addr), 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 0, 8'(m_lc), 8'd0);

        // Start and clear together while idle; start while active is ignored.
        do_reset();
        step(1, 0, 1, 0, 0, 0, 8'd0, 8'd0);
        chk("t5_stay_idle", 32'(l_busy), 0);
        step(0, 0, 0, 0, 1, 0, 8'h11, 8'd0);
        step(1, 0, 0, 0, 0, 0, 8'd0, 8'd0);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 1, 0, 8'(m_lc), 8'd0);
        step(1, 0, 0, 0, 1, 0, 8'h99, 8'd0);
        chk("t5_no_restart_addr", 32'(mem_addr), 10);

        // Mid-frame reset, then valid alone must not be accepted.
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 0, 8'(m_lc), 8'd0);
        do_reset();
        w0 = writes;
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 1, 8'h55, 8'h66);
        chk("t6_no_writes", 32'(writes - w0), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
